rock_motion_monitor: RTL and testbench

//  Measures the cradle's rocking motion from a signed position sample stream.

---
 rtl/rock_pkg.sv | 27 ++
 rtl/rock_zero_cross.sv | 52 +++++
 rtl/rock_motion_monitor.sv | 141 ++++++++++++++
 tb/tb_rock_motion_monitor.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rock_pkg.sv
// rtl/rock_pkg.sv - shared state enum, default widths and |sample| saturation helper
package rock_pkg;

    localparam int SW_DEF = 12;
    localparam int CW_DEF = 16;

    typedef enum logic [1:0] {
        ARM     = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2,
        STALL   = 2'd3
    } rock_state_t;

    // Magnitude of a w-bit signed value; the most negative code saturates to 2**(w-1)-1
    function automatic logic [31:0] abs_sat(input logic signed [31:0] v, input int w);
        logic signed [31:0] lim;
        lim = 32'sd1 <<< (w - 1);
        if (v <= -lim) begin
            abs_sat = lim - 32'sd1;
        end else if (v < 0) begin
            abs_sat = -v;
        end else begin
            abs_sat = v;
        end
    endfunction

endpackage

// File: rtl/rock_zero_cross.sv
// rtl/rock_zero_cross.sv - rising zero-crossing detector (hysteresis with ZC_HYST_EN)
module rock_zero_cross
    import rock_pkg::*;
#(
    parameter int SW      = SW_DEF,
    parameter int ZC_HYST = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic signed [SW-1:0] sample,
    output logic                 zc_pulse
);

    localparam logic signed [SW-1:0] HYST_P = SW'(ZC_HYST);
    localparam logic signed [SW-1:0] HYST_N = -HYST_P;

`ifdef ZC_HYST_EN
    logic low_seen;

    assign zc_pulse = sample_valid && low_seen && (sample >= HYST_P);

    // Remember that the swing went below -ZC_HYST since the last qualifying crossing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            low_seen <= 1'b0;
        end else if (sample_valid) begin
            if (sample <= HYST_N) begin
                low_seen <= 1'b1;
            end else if (zc_pulse) begin
                low_seen <= 1'b0;
            end
        end
    end
`else
    logic prev_neg;
    logic unused_cfg;

    assign zc_pulse   = sample_valid && prev_neg && !sample[SW-1];
    assign unused_cfg = ^{sample[SW-2:0], HYST_P, HYST_N};

    // Sign of the previous strobed sample
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_neg <= 1'b0;
        end else if (sample_valid) begin
            prev_neg <= sample[SW-1];
        end
    end
`endif

endmodule

// File: rtl/rock_motion_monitor.sv
// rtl/rock_motion_monitor.sv - rocking period/amplitude monitor emitting Alaag/Fhoog/Flaag; option macro ZC_HYST_EN
module rock_motion_monitor
    import rock_pkg::*;
#(
    parameter int SW        = SW_DEF,
    parameter int CW        = CW_DEF,
    parameter int PER_MIN   = 400,
    parameter int PER_MAX   = 600,
    parameter int AMP_MIN   = 512,
    parameter int PER_LIMIT = 2000,
    parameter int ZC_HYST   = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_valid,
    input  logic signed [SW-1:0] sample,
    output logic                 Alaag,
    output logic                 Fhoog,
    output logic                 Flaag,
    output logic                 meas_valid,
    output logic [CW-1:0]        period_out,
    output logic [SW-2:0]        amp_out
);

    localparam logic [CW-1:0] PER_MIN_C   = CW'(PER_MIN);
    localparam logic [CW-1:0] PER_MAX_C   = CW'(PER_MAX);
    localparam logic [CW-1:0] PER_LIMIT_C = CW'(PER_LIMIT);
    localparam logic [SW-2:0] AMP_MIN_C   = (SW-1)'(AMP_MIN);

    rock_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, base_cnt, inc_cnt;
    logic [SW-2:0] peak_q, peak_d, base_peak, inc_peak;
    logic [31:0]   abs_wide;
    logic [SW-2:0] sample_abs;
    logic          zc_pulse;
    logic          rep, stall;
    logic          unused_abs_hi;

    assign abs_wide      = abs_sat(32'(sample), SW);
    assign sample_abs    = abs_wide[SW-2:0];
    assign unused_abs_hi = ^abs_wide[31:SW-1];

    rock_zero_cross #(
        .SW      (SW),
        .ZC_HYST (ZC_HYST)
    ) u_zc (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .zc_pulse     (zc_pulse)
    );

    // Next state and measurement update; REPORT/STALL restart from empty counters and
    // treat a coincident strobe as the first strobe of the new period
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        peak_d    = peak_q;
        rep       = 1'b0;
        stall     = 1'b0;
        base_cnt  = cnt_q;
        base_peak = peak_q;
        if (state_q == REPORT || state_q == STALL) begin
            base_cnt  = '0;
            base_peak = '0;
            cnt_d     = '0;
            peak_d    = '0;
            state_d   = MEASURE;
        end
        inc_cnt  = (base_cnt == '1) ? base_cnt : base_cnt + CW'(1);
        inc_peak = (sample_abs > base_peak) ? sample_abs : base_peak;
        case (state_q)
            ARM: begin
                if (zc_pulse) begin
                    state_d = MEASURE;
                    cnt_d   = '0;
                    peak_d  = '0;
                end
            end
            default: begin
                if (sample_valid) begin
                    cnt_d  = inc_cnt;
                    peak_d = inc_peak;
                    if (zc_pulse) begin
                        state_d = REPORT;
                        rep     = 1'b1;
                    end else if (inc_cnt >= PER_LIMIT_C) begin
                        state_d = STALL;
                        stall   = 1'b1;
                    end
                end
            end
        endcase
    end

    // State, period counter and peak tracker registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ARM;
            cnt_q   <= '0;
            peak_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            peak_q  <= peak_d;
        end
    end

    // Result latch and single-cycle event pulses, loaded on the edge that enters REPORT/STALL
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meas_valid <= 1'b0;
            Alaag      <= 1'b0;
            Fhoog      <= 1'b0;
            Flaag      <= 1'b0;
            period_out <= '0;
            amp_out    <= '0;
        end else begin
            meas_valid <= 1'b0;
            Alaag      <= 1'b0;
            Fhoog      <= 1'b0;
            Flaag      <= 1'b0;
            if (rep) begin
                meas_valid <= 1'b1;
                period_out <= cnt_d;
                amp_out    <= peak_d;
                Fhoog      <= (cnt_d < PER_MIN_C);
                Flaag      <= (cnt_d > PER_MAX_C);
                Alaag      <= (peak_d < AMP_MIN_C);
            end else if (stall) begin
                meas_valid <= 1'b1;
                period_out <= PER_LIMIT_C;
                amp_out    <= peak_d;
                Flaag      <= 1'b1;
                Alaag      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rock_motion_monitor.sv
// tb/tb_rock_motion_monitor.sv - scoreboard bench with a behavioural rocking-motion model
module tb_rock_motion_monitor;

    localparam int SW        = 12;
    localparam int CW        = 16;
    localparam int PER_MIN   = 400;
    localparam int PER_MAX   = 600;
    localparam int AMP_MIN   = 512;
    localparam int PER_LIMIT = 2000;
    localparam int ZC_HYST   = 64;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 sample_valid = 1'b0;
    logic signed [SW-1:0] sample = '0;
    logic                 Alaag, Fhoog, Flaag, meas_valid;
    logic [CW-1:0]        period_out;
    logic [SW-2:0]        amp_out;

    rock_motion_monitor dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .Alaag        (Alaag),
        .Fhoog        (Fhoog),
        .Flaag        (Flaag),
        .meas_valid   (meas_valid),
        .period_out   (period_out),
        .amp_out      (amp_out)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        int     period;
        int     amp;
        bit     al;
        bit     fh;
        bit     fl;
        longint at;
    } exp_t;

    exp_t sb[$];

    // Reference model state: strobes since last crossing, running peak
    bit m_armed;
    bit m_prev_neg;
    bit m_low;
    int m_cnt;
    int m_peak;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic model_clear();
        m_armed    = 1'b0;
        m_prev_neg = 1'b0;
        m_low      = 1'b0;
        m_cnt      = 0;
        m_peak     = 0;
    endtask

    task automatic push(input int per, input int amp, input bit al, input bit fh, input bit fl);
        exp_t e;
        e.period = per;
        e.amp    = amp;
        e.al     = al;
        e.fh     = fh;
        e.fl     = fl;
        e.at     = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic model_strobe(input int v);
        bit zc;
        int a;
        a = (v < 0) ? -v : v;
        if (a > 2047) a = 2047;
`ifdef ZC_HYST_EN
        zc = m_low && (v >= ZC_HYST);
        if (v <= -ZC_HYST) m_low = 1'b1;
        else if (zc) m_low = 1'b0;
`else
        zc = m_prev_neg && (v >= 0);
        m_prev_neg = (v < 0);
`endif
        if (!m_armed) begin
            if (zc) begin
                m_armed = 1'b1;
                m_cnt   = 0;
                m_peak  = 0;
            end
        end else begin
            m_cnt++;
            if (a > m_peak) m_peak = a;
            if (zc) begin
                push(m_cnt, m_peak, m_peak < AMP_MIN, m_cnt < PER_MIN, m_cnt > PER_MAX);
                m_cnt  = 0;
                m_peak = 0;
            end else if (m_cnt == PER_LIMIT) begin
                push(PER_LIMIT, m_peak, 1'b1, 1'b0, 1'b1);
                m_cnt  = 0;
                m_peak = 0;
            end
        end
    endtask

    task automatic drive(input bit v, input int val);
        @(posedge clk);
        #1;
        sample_valid = v;
        sample       = SW'(val);
        if (v) model_strobe(val);
    endtask

    // One wave period in strobes: negative half then positive half, optional idle gaps and jitter
    task automatic square(input int per, input int neg_amp, input int pos_amp, input int gap_pct, input bit jitter);
        int val;
        for (int i = 0; i < per; i++) begin
            val = (i < per / 2) ? -neg_amp : pos_amp;
            if (jitter && (i < 3 || (i >= per / 2 && i < per / 2 + 3)))
                val = int'($urandom_range(0, 60)) - 30;
            if (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) drive(1'b0, val);
            drive(1'b1, val);
        end
    endtask

    task automatic reset_outputs_check();
        check("rst_meas_valid", meas_valid, 0);
        check("rst_Alaag", Alaag, 0);
        check("rst_Fhoog", Fhoog, 0);
        check("rst_Flaag", Flaag, 0);
        check("rst_period_out", period_out, 0);
        check("rst_amp_out", amp_out, 0);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #1;
        reset        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        #2;
        reset_outputs_check();
        sb.delete();
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: pop the scoreboard whenever the DUT reports, flag stray or late results
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (meas_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_meas actual period=%0d amp=%0d required=none", period_out, amp_out);
                end else begin
                    e = sb.pop_front();
                    check("meas_cycle", cyc, e.at);
                    check("period_out", period_out, e.period);
                    check("amp_out", amp_out, e.amp);
                    check("Alaag", Alaag, e.al);
                    check("Fhoog", Fhoog, e.fh);
                    check("Flaag", Flaag, e.fl);
                end
            end else if (Alaag || Fhoog || Flaag) begin
                checks++;
                failures++;
                $display("FAIL stray_event actual=%b%b%b required=000", Alaag, Fhoog, Flaag);
            end
            if (sb.size() > 0 && cyc > sb[0].at) begin
                checks++;
                failures++;
                $display("FAIL missing_meas actual=none required period=%0d at cycle %0d", sb[0].period, sb[0].at);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        int per;
        int amp;
        model_clear();
        repeat (3) @(posedge clk);
        #2;
        reset_outputs_check();
        @(posedge clk);
        #1;
        reset = 1'b1;

        repeat (5) square(500, 1000, 1000, 0, 1'b0);
        repeat (5) square(300, 1000, 1000, 0, 1'b0);
        repeat (4) square(700, 200, 200, 25, 1'b0);
        for (int k = 0; k < 6; k++) begin
            per = int'($urandom_range(350, 650));
            amp = int'($urandom_range(300, 900));
            square(per, amp, amp, 10, 1'b0);
        end
        repeat (4500) drive(1'b1, 100);
        repeat (3) square(500, 2048, 1000, 0, 1'b0);
        repeat (4) square(500, 1000, 1000, 0, 1'b1);

        repeat (150) drive(1'b1, -500);
        mid_reset();
        repeat (50) drive(1'b1, 500);
        repeat (50) drive(1'b1, -500);
        repeat (50) drive(1'b1, 500);
        repeat (3) square(500, 1000, 1000, 0, 1'b0);

        repeat (5) drive(1'b0, 0);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
